// File: rtl/light_monitor_if.sv
// Light-code bus between the intersection controller and the light monitor.
// Master drives the light codes; slave returns lamp drives and status.
interface light_monitor_if #(
    parameter int CNT_W = 8
);
    logic [1:0]       hwy;
    logic [1:0]       cntry;
    logic [2:0]       hwy_lamp;
    logic [2:0]       cntry_lamp;
    logic             fault;
    logic [2:0]       fault_code;
    logic [CNT_W-1:0] svc_cnt;

    modport master (
        output hwy,
        output cntry,
        input  hwy_lamp,
        input  cntry_lamp,
        input  fault,
        input  fault_code,
        input  svc_cnt
    );

    modport slave (
        input  hwy,
        input  cntry,
        output hwy_lamp,
        output cntry_lamp,
        output fault,
        output fault_code,
        output svc_cnt
    );
endinterface

// File: rtl/light_monitor.sv
// Intersection light monitor: decodes light codes to lamps, enforces the
// safety protocol, latches the first violation and flashes red until clear.
module light_monitor #(
    parameter logic [1:0] RED        = 2'd0,
    parameter logic [1:0] YELLOW     = 2'd1,
    parameter logic [1:0] GREEN      = 2'd2,
    parameter int         MIN_YELLOW = 4,
    parameter int         MIN_ALLRED = 3,
    parameter int         FLASH_HALF = 8,
    parameter int         CNT_W      = 8
) (
    input logic            clk,
    input logic            clear,
    light_monitor_if.slave bus
);

    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam int AW = $clog2(MIN_ALLRED + 1);
    localparam int FW = $clog2(2 * FLASH_HALF);

    localparam logic [YW-1:0] YSAT  = YW'(MIN_YELLOW);
    localparam logic [AW-1:0] ASAT  = AW'(MIN_ALLRED);
    localparam logic [FW-1:0] FLAST = FW'(2 * FLASH_HALF - 1);
    localparam logic [FW-1:0] FHALF = FW'(FLASH_HALF);

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_FAULT
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       cur_h_q, cur_h_d;
    logic [1:0]       cur_c_q, cur_c_d;
    logic [1:0]       prev_h_q, prev_h_d;
    logic [1:0]       prev_c_q, prev_c_d;
    logic [YW-1:0]    yh_q, yh_d;
    logic [YW-1:0]    yc_q, yc_d;
    logic [AW-1:0]    ar_q, ar_d;
    logic [FW-1:0]    flash_q, flash_d;
    logic [2:0]       hl_q, hl_d;
    logic [2:0]       cl_q, cl_d;
    logic             fault_q, fault_d;
    logic [2:0]       fcode_q, fcode_d;
    logic [CNT_W-1:0] svc_q, svc_d;

    logic       v_ill, v_both, v_g2r, v_skip, v_shorty, v_allred;
    logic       trans_en;
    logic [2:0] vcode;

    function automatic logic [2:0] dec(input logic [1:0] code);
        logic [2:0] l;
        l = L_OFF;
        unique case (1'b1)
            (code == RED):    l = L_RED;
            (code == YELLOW): l = L_YEL;
            (code == GREEN):  l = L_GRN;
            default:          l = L_OFF;
        endcase
        return l;
    endfunction

    function automatic logic [YW-1:0] ynext(input logic [1:0] code,
                                            input logic [YW-1:0] cnt);
        logic [YW-1:0] n;
        n = '0;
        if (code == YELLOW) begin
            n = (cnt == YSAT) ? cnt : cnt + YW'(1);
        end
        return n;
    endfunction

    function automatic logic bad_step(input logic [1:0] p,
                                      input logic [1:0] c);
        return ((p == RED) && (c == YELLOW)) ||
               ((p == YELLOW) && (c == GREEN));
    endfunction

    // Level checks look at cur only; transition checks need valid prev.
    always_comb begin
        v_ill    = (cur_h_q == 2'd3) || (cur_c_q == 2'd3);
        v_both   = (cur_h_q != RED) && (cur_c_q != RED);
        v_g2r    = ((prev_h_q == GREEN) && (cur_h_q == RED)) ||
                   ((prev_c_q == GREEN) && (cur_c_q == RED));
        v_skip   = bad_step(prev_h_q, cur_h_q) ||
                   bad_step(prev_c_q, cur_c_q);
        v_shorty = ((prev_h_q == YELLOW) && (cur_h_q == RED) &&
                    (yh_q < YSAT)) ||
                   ((prev_c_q == YELLOW) && (cur_c_q == RED) &&
                    (yc_q < YSAT));
        v_allred = (((prev_h_q == RED) && (cur_h_q == GREEN)) ||
                    ((prev_c_q == RED) && (cur_c_q == GREEN))) &&
                   (ar_q < ASAT);
    end

    assign trans_en = (state_q == S_RUN);

    always_comb begin
        vcode = 3'd0;
        if (v_ill) begin
            vcode = 3'd1;
        end else if (v_both) begin
            vcode = 3'd2;
        end else if (trans_en && v_g2r) begin
            vcode = 3'd3;
        end else if (trans_en && v_skip) begin
            vcode = 3'd4;
        end else if (trans_en && v_shorty) begin
            vcode = 3'd5;
        end else if (trans_en && v_allred) begin
            vcode = 3'd6;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_h_d  = bus.hwy;
        cur_c_d  = bus.cntry;
        prev_h_d = cur_h_q;
        prev_c_d = cur_c_q;
        yh_d     = yh_q;
        yc_d     = yc_q;
        ar_d     = ar_q;
        flash_d  = flash_q;
        hl_d     = hl_q;
        cl_d     = cl_q;
        fault_d  = fault_q;
        fcode_d  = fcode_q;
        svc_d    = svc_q;

        unique case (state_q)
            S_INIT, S_RUN: begin
                if (vcode != 3'd0) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    fcode_d = vcode;
                    hl_d    = L_RED;
                    cl_d    = L_RED;
                    flash_d = '0;
                end else begin
                    state_d = S_RUN;
                    hl_d    = dec(cur_h_q);
                    cl_d    = dec(cur_c_q);
                    yh_d    = ynext(cur_h_q, yh_q);
                    yc_d    = ynext(cur_c_q, yc_q);
                    if ((cur_h_q == RED) && (cur_c_q == RED)) begin
                        ar_d = (ar_q == ASAT) ? ar_q : ar_q + AW'(1);
                    end else begin
                        ar_d = '0;
                    end
                    if (trans_en && (prev_c_q == YELLOW) &&
                        (cur_c_q == RED)) begin
                        svc_d = svc_q + CNT_W'(1);
                    end
                end
            end
            S_FAULT: begin
                // Everything but the flash phase holds until clear.
                cur_h_d  = cur_h_q;
                cur_c_d  = cur_c_q;
                prev_h_d = prev_h_q;
                prev_c_d = prev_c_q;
                flash_d  = (flash_q == FLAST) ? '0 : flash_q + FW'(1);
                hl_d     = (flash_d < FHALF) ? L_RED : L_OFF;
                cl_d     = (flash_d < FHALF) ? L_RED : L_OFF;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // The clear edge still samples the codes so INIT sees fresh input.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= S_INIT;
            cur_h_q  <= bus.hwy;
            cur_c_q  <= bus.cntry;
            prev_h_q <= RED;
            prev_c_q <= RED;
            yh_q     <= '0;
            yc_q     <= '0;
            ar_q     <= ASAT;
            flash_q  <= '0;
            hl_q     <= L_RED;
            cl_q     <= L_RED;
            fault_q  <= 1'b0;
            fcode_q  <= 3'd0;
            svc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_h_q  <= cur_h_d;
            cur_c_q  <= cur_c_d;
            prev_h_q <= prev_h_d;
            prev_c_q <= prev_c_d;
            yh_q     <= yh_d;
            yc_q     <= yc_d;
            ar_q     <= ar_d;
            flash_q  <= flash_d;
            hl_q     <= hl_d;
            cl_q     <= cl_d;
            fault_q  <= fault_d;
            fcode_q  <= fcode_d;
            svc_q    <= svc_d;
        end
    end

    assign bus.hwy_lamp   = hl_q;
    assign bus.cntry_lamp = cl_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = fcode_q;
    assign bus.svc_cnt    = svc_q;

endmodule

// File: tb/tb_light_monitor.sv
// Bench for light_monitor: vector table plus scoreboard of expected outputs.
// A second instance with a 2-bit service counter checks wrap-around.
module tb_light_monitor;

    localparam logic [1:0] R  = 2'd0;
    localparam logic [1:0] Y  = 2'd1;
    localparam logic [1:0] G  = 2'd2;
    localparam logic [1:0] X3 = 2'd3;
    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;
    localparam logic [2:0] LO = 3'b000;

    typedef struct {
        logic [1:0] h;
        logic [1:0] c;
        int         n;
        logic [2:0] hl;
        logic [2:0] cl;
        logic       f;
        logic [2:0] fc;
        logic [7:0] svc;
        string      nm;
    } vec_t;

    typedef struct {
        int         due;
        logic [2:0] hl;
        logic [2:0] cl;
        logic       f;
        logic [2:0] fc;
        logic [7:0] svc;
        string      nm;
    } exp_t;

    logic clk;
    logic clear;
    int   cyc;
    int   total;
    int   bad;
    exp_t sbq[$];
    vec_t tbl[$];

    light_monitor_if #(.CNT_W(8)) ifa ();
    light_monitor_if #(.CNT_W(2)) ifb ();

    light_monitor #(.CNT_W(8)) dut_a (
        .clk   (clk),
        .clear (clear),
        .bus   (ifa.slave)
    );

    light_monitor #(.CNT_W(2)) dut_b (
        .clk   (clk),
        .clear (clear),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input string fld,
                       input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s cyc=%0d got=%0h want=%0h",
                     nm, fld, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            if (e.due < cyc) begin
                total++;
                bad++;
                $display("FAIL %s stale due=%0d cyc=%0d", e.nm, e.due, cyc);
            end else begin
                chk(e.nm, "hwy_lamp", {5'd0, ifa.hwy_lamp}, {5'd0, e.hl});
                chk(e.nm, "cntry_lamp", {5'd0, ifa.cntry_lamp}, {5'd0, e.cl});
                chk(e.nm, "fault", {7'd0, ifa.fault}, {7'd0, e.f});
                chk(e.nm, "fault_code", {5'd0, ifa.fault_code}, {5'd0, e.fc});
                chk(e.nm, "svc_cnt", ifa.svc_cnt, e.svc);
                chk(e.nm, "svc_cnt_w2", {6'd0, ifb.svc_cnt},
                    {6'd0, e.svc[1:0]});
                chk(e.nm, "fault_w2", {7'd0, ifb.fault}, {7'd0, e.f});
            end
        end
    end

    task automatic set_in(input logic [1:0] h, input logic [1:0] c);
        ifa.hwy   = h;
        ifa.cntry = c;
        ifb.hwy   = h;
        ifb.cntry = c;
    endtask

    task automatic drive(input logic [1:0] h, input logic [1:0] c,
                         input int n, input logic [2:0] hl,
                         input logic [2:0] cl, input logic f,
                         input logic [2:0] fc, input logic [7:0] svc,
                         input string nm);
        for (int i = 0; i < n; i++) begin
            set_in(h, c);
            sbq.push_back('{cyc + 2, hl, cl, f, fc, svc, nm});
            @(posedge clk);
            #1;
        end
    endtask

    // One unchecked settling cycle, then clear with a G/R startup code.
    task automatic do_clear(input int n);
        @(posedge clk);
        #1;
        set_in(G, R);
        clear = 1'b1;
        for (int i = 0; i < n; i++) begin
            sbq.push_back('{cyc + 1, LR, LR, 1'b0, 3'd0, 8'd0, "clear"});
            @(posedge clk);
            #1;
        end
        clear = 1'b0;
    endtask

    initial begin
        int s;
        total = 0;
        bad   = 0;
        clear = 1'b1;
        set_in(G, R);

        // Legal full cycle, table driven.
        tbl.push_back('{G, R, 10, LG, LR, 1'b0, 3'd0, 8'd0, "t1_gr"});
        tbl.push_back('{Y, R, 4,  LY, LR, 1'b0, 3'd0, 8'd0, "t1_yr"});
        tbl.push_back('{R, R, 3,  LR, LR, 1'b0, 3'd0, 8'd0, "t1_rr"});
        tbl.push_back('{R, G, 5,  LR, LG, 1'b0, 3'd0, 8'd0, "t1_rg"});
        tbl.push_back('{R, Y, 4,  LR, LY, 1'b0, 3'd0, 8'd0, "t1_ry"});
        tbl.push_back('{R, R, 3,  LR, LR, 1'b0, 3'd0, 8'd1, "t1_rr2"});
        tbl.push_back('{G, R, 3,  LG, LR, 1'b0, 3'd0, 8'd1, "t1_gr2"});
        do_clear(2);
        foreach (tbl[k]) begin
            drive(tbl[k].h, tbl[k].c, tbl[k].n, tbl[k].hl, tbl[k].cl,
                  tbl[k].f, tbl[k].fc, tbl[k].svc, tbl[k].nm);
        end

        // Both green, then flash pattern with legal inputs ignored.
        drive(G, G, 1, LR, LR, 1'b1, 3'd2, 8'd1, "t2_gg");
        drive(G, R, 7, LR, LR, 1'b1, 3'd2, 8'd1, "t2_on");
        drive(G, R, 8, LO, LO, 1'b1, 3'd2, 8'd1, "t2_off");
        drive(R, R, 2, LR, LR, 1'b1, 3'd2, 8'd1, "t2_on2");

        // Short yellow.
        do_clear(2);
        drive(G, R, 5, LG, LR, 1'b0, 3'd0, 8'd0, "t3a_gr");
        drive(Y, R, 3, LY, LR, 1'b0, 3'd0, 8'd0, "t3a_yr");
        drive(R, R, 2, LR, LR, 1'b1, 3'd5, 8'd0, "t3a_short");

        // Skipped yellow.
        do_clear(2);
        drive(G, R, 5, LG, LR, 1'b0, 3'd0, 8'd0, "t3b_gr");
        drive(R, R, 2, LR, LR, 1'b1, 3'd3, 8'd0, "t3b_skip");

        // All-red too short.
        do_clear(2);
        drive(G, R, 5, LG, LR, 1'b0, 3'd0, 8'd0, "t4a_gr");
        drive(Y, R, 4, LY, LR, 1'b0, 3'd0, 8'd0, "t4a_yr");
        drive(R, R, 2, LR, LR, 1'b0, 3'd0, 8'd0, "t4a_rr");
        drive(R, G, 2, LR, LR, 1'b1, 3'd6, 8'd0, "t4a_allred");

        // All-red exactly at the minimum.
        do_clear(2);
        drive(G, R, 5, LG, LR, 1'b0, 3'd0, 8'd0, "t4b_gr");
        drive(Y, R, 4, LY, LR, 1'b0, 3'd0, 8'd0, "t4b_yr");
        drive(R, R, 3, LR, LR, 1'b0, 3'd0, 8'd0, "t4b_rr");
        drive(R, G, 3, LR, LG, 1'b0, 3'd0, 8'd0, "t4b_rg");

        // Illegal code beats both-non-red.
        do_clear(2);
        drive(G, R, 5, LG, LR, 1'b0, 3'd0, 8'd0, "t5_gr");
        drive(X3, G, 2, LR, LR, 1'b1, 3'd1, 8'd0, "t5_ill");

        // Four full service cycles: 2-bit counter wraps to 0.
        do_clear(2);
        drive(G, R, 3, LG, LR, 1'b0, 3'd0, 8'd0, "t6_gr");
        s = 0;
        for (int k = 0; k < 4; k++) begin
            drive(Y, R, 4, LY, LR, 1'b0, 3'd0, 8'(s), "t6_yr");
            drive(R, R, 3, LR, LR, 1'b0, 3'd0, 8'(s), "t6_rr");
            drive(R, G, 3, LR, LG, 1'b0, 3'd0, 8'(s), "t6_rg");
            drive(R, Y, 4, LR, LY, 1'b0, 3'd0, 8'(s), "t6_ry");
            s++;
            drive(R, R, 3, LR, LR, 1'b0, 3'd0, 8'(s), "t6_rr2");
            drive(G, R, 3, LG, LR, 1'b0, 3'd0, 8'(s), "t6_gr2");
        end

        // Clear in the middle of a fault, then a clean G/R startup.
        drive(G, G, 1, LR, LR, 1'b1, 3'd2, 8'd4, "t6b_gg");
        drive(G, R, 3, LR, LR, 1'b1, 3'd2, 8'd4, "t6b_on");
        do_clear(1);
        drive(G, R, 6, LG, LR, 1'b0, 3'd0, 8'd0, "t6b_restart");

        repeat (4) @(posedge clk);
        #1;
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/light_monitor.md
Name: light_monitor

Overview:
- Sits downstream of the intersection controller and consumes the encoded hwy/cntry light codes.
- Decodes each code into a one-hot lamp drive.
- Checks every code sequence against the intersection safety protocol. On the first violation it latches a fault code and forces both roads to flashing red until clear.
- Counts completed country-road service cycles for status readout.

Parameters:
- RED, 2'd0, light code for red
- YELLOW, 2'd1, light code for yellow
- GREEN, 2'd2, light code for green (2'd3 is illegal)
- MIN_YELLOW, 4, minimum consecutive cycles a road must hold YELLOW
- MIN_ALLRED, 3, minimum consecutive all-red cycles before either road may turn GREEN
- FLASH_HALF, 8, half-period of fault flashing, in cycles
- CNT_W, 8, width of the service counter

Ports:
- clk  input  1  clock, all logic on posedge
- clear  input  1  synchronous active-high reset
- hwy  input  2  highway light code
- cntry  input  2  country light code
- hwy_lamp  output  3  highway lamps {R,Y,G}, one-hot or all-off
- cntry_lamp  output  3  country lamps {R,Y,G}
- fault  output  1  latched protocol violation
- fault_code  output  3  cause of the first violation; 0 = none
- svc_cnt  output  CNT_W  completed country service cycles

Behaviour:
- One clock; reset is synchronous and active-high, port clear, sampled on posedge clk. clear has priority over everything, including the FAULT state.
- Reset values:
  - hwy_lamp = cntry_lamp = 3'b100
  - fault = 0, fault_code = 0, svc_cnt = 0
  - state INIT
  - dwell counters 0
  - all-red counter preloaded to MIN_ALLRED, so startup directly into GREEN is legal.
- Pipeline:
  - Each edge registers cur_h/cur_c ← hwy/cntry and prev ← cur.
  - Checks compare cur against prev combinationally; lamps, fault and counters are registered from them.
  - Input-to-lamp and input-to-fault latency is 2 edges.
- States:
  - INIT: the first valid cur is loaded; transition checks are disabled and level checks are active. Go to RUN.
  - RUN: lamps = one-hot decode of cur (RED→100, YELLOW→010, GREEN→001). All checks are active. Any violation → FAULT.
  - FAULT: terminal until clear. Inputs, counters and fault_code are frozen.
- Flashing in FAULT:
  - Both lamps show 3'b100 for FLASH_HALF cycles, then 3'b000 for FLASH_HALF cycles, repeating.
  - The flash phase starts at 100 on the first FAULT cycle.
- Checks in RUN (codes; lowest code wins when several fire in the same cycle):
  - 1: either cur code = 2'd3.
  - 2: both roads non-RED in cur.
  - 3: GREEN→RED on either road (yellow skipped).
  - 4: RED→YELLOW or YELLOW→GREEN on either road.
  - 5: YELLOW→RED with yellow dwell < MIN_YELLOW. The dwell counter counts consecutive YELLOW cycles per road, saturating at MIN_YELLOW and clearing on leaving YELLOW.
  - 6: RED→GREEN on either road with all-red count < MIN_ALLRED. The all-red count is the number of consecutive cycles both prev codes were RED, saturating at MIN_ALLRED and clearing when any road is non-RED.
- Codes are only checked on change. A steady legal code never faults.
- fault and fault_code assert on the same edge the lamps would have shown the offending code. That edge shows flash-red instead; the offending code never reaches a lamp.
- svc_cnt:
  - Increments on a legal cntry YELLOW→RED transition.
  - Wraps modulo 2^CNT_W.
  - No increment on the edge that raises fault.
- clear mid-fault or mid-dwell:
  - All outputs return to reset values on that edge.
  - The next edge re-enters INIT; stale prev history is never compared.

Test Plan:
1. Legal cycle: clear 2 cycles; hwy=G/cntry=R 10 cycles → Y/R 4 → R/R 3 → R/G 5 → R/Y 4 → R/R 3 → G/R. Required: fault=0; lamps track inputs 2 edges late; svc_cnt=1.
2. Both green: from legal G/R, drive G/G one cycle. Required: fault=1, fault_code=2; both lamps 100 for 8 cycles, then 000 for 8; later legal inputs ignored.
3. Short yellow and skipped yellow, separate runs:
   - hwy Y for 3 cycles then R → fault_code=5.
   - hwy G→R directly → fault_code=3.
4. All-red boundary:
   - R/R for 2 cycles then R/G → fault_code=6.
   - Repeat with 3 all-red cycles → no fault.
5. Priority and illegal code: drive hwy=3, cntry=G in the same cycle (violates codes 1 and 2). Required: fault_code=1.
6. Reset cases:
   - Wrap: CNT_W=2, four legal cycles → svc_cnt=0 after the fourth; no fault.
   - clear mid-fault: on that edge lamps=100/100, fault=0, fault_code=0, svc_cnt=0; a subsequent startup in G/R raises no fault.
